// File: rtl/psum_quant_pkg.sv
// Shared widths, activation constants and data types for the partial-sum
// requantization path (accumulator plus the reusable quant_act_sat stages).
package psum_quant_pkg;

    localparam int IN_W        = 20;
    localparam int ACC_W       = 32;
    localparam int BIAS_W      = 16;
    localparam int OUT_W       = 8;
    localparam int CNT_W       = 10;
    localparam int LEAKY_SHIFT = 3;
    localparam int OUT_MAX     = 127;
    localparam int OUT_MIN     = -128;

    typedef logic signed [ACC_W-1:0] psum_t;
    typedef logic signed [OUT_W-1:0] out_t;

endpackage

// File: rtl/quant_act_sat.sv
// Stages S2 (rounding right shift) and S3 (leaky ReLU, saturation, output
// register). sat_o flags a clipped result and is valid together with vld_o.
module quant_act_sat
    import psum_quant_pkg::*;
(
    input  logic        clk,
    input  logic        rstn,
    input  logic        vld_i,
    input  psum_t       sum_i,
    input  logic [4:0]  shift_i,
    input  logic        relu_en_i,
    output out_t        out_o,
    output logic        vld_o,
    output logic        sat_o
);

    logic signed [ACC_W:0] wide;
    logic signed [ACC_W:0] rnd;
    logic signed [ACC_W:0] shifted;
    psum_t                 r_d;
    psum_t                 r_q;
    logic                  relu_q;
    logic                  vld2_q;
    psum_t                 act;
    logic                  clip_hi;
    logic                  clip_lo;
    out_t                  out_d;
    out_t                  out_q;
    logic                  vld_q;
    logic                  sat_q;
    logic                  unused_msb;

    // One extra bit keeps the rounding add from wrapping before the shift.
    always_comb begin
        wide    = {sum_i[ACC_W-1], sum_i};
        rnd     = '0;
        shifted = wide;
        r_d     = sum_i;
        if (shift_i != 5'd0) begin
            rnd     = (ACC_W+1)'(1) <<< (shift_i - 5'd1);
            shifted = (wide + rnd) >>> shift_i;
            r_d     = shifted[ACC_W-1:0];
        end
    end

    assign unused_msb = shifted[ACC_W];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_q    <= '0;
            relu_q <= 1'b0;
            vld2_q <= 1'b0;
        end else begin
            vld2_q <= vld_i;
            if (vld_i) begin
                r_q    <= r_d;
                relu_q <= relu_en_i;
            end
        end
    end

    always_comb begin
        act     = r_q;
        if (relu_q && (r_q < 0)) begin
            act = r_q >>> LEAKY_SHIFT;
        end
        clip_hi = act > psum_t'(OUT_MAX);
        clip_lo = act < psum_t'(OUT_MIN);
        out_d   = act[OUT_W-1:0];
        if (clip_hi) begin
            out_d = out_t'(OUT_MAX);
        end else if (clip_lo) begin
            out_d = out_t'(OUT_MIN);
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            out_q <= '0;
            vld_q <= 1'b0;
            sat_q <= 1'b0;
        end else begin
            vld_q <= vld2_q;
            sat_q <= vld2_q & (clip_hi | clip_lo);
            if (vld2_q) begin
                out_q <= out_d;
            end
        end
    end

    assign out_o = out_q;
    assign vld_o = vld_q;
    assign sat_o = sat_q;

endmodule

// File: rtl/psum_quant.sv
// Accumulates MAC partial sums per output pixel, adds bias and requantizes to
// int8. Optional saturation counter behind macro PSUM_QUANT_SAT_CNT_EN.
module psum_quant
    import psum_quant_pkg::*;
(
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     clr_i,
    input  logic [CNT_W-1:0]         num_chunk_i,
    input  logic signed [BIAS_W-1:0] bias_i,
    input  logic [4:0]               shift_i,
    input  logic                     relu_en_i,
    input  logic                     vld_i,
    input  logic signed [IN_W-1:0]   acc_i,
    output logic signed [OUT_W-1:0]  out_o,
    output logic                     vld_o
`ifdef PSUM_QUANT_SAT_CNT_EN
   ,output logic [15:0]              sat_cnt_o
`endif
);

    // Valid-only stream, no ready: every vld_i beat is consumed in its cycle
    // and vld_o is a one-cycle pulse that the sink must take immediately.

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] last_q, last_d;
    psum_t            psum_q, psum_d;
    psum_t            s1_sum_q, s1_sum_d;
    logic [4:0]       s1_shift_q, s1_shift_d;
    logic             s1_relu_q, s1_relu_d;
    logic             s1_vld_q, s1_vld_d;

    psum_t            acc_ext;
    psum_t            bias_ext;
    psum_t            psum_base;
    logic [CNT_W-1:0] n_in;
    logic [CNT_W-1:0] last_idx;
    logic             first;
    logic             is_last;
    logic             sat_w;

    assign acc_ext   = {{(ACC_W-IN_W){acc_i[IN_W-1]}}, acc_i};
    assign bias_ext  = {{(ACC_W-BIAS_W){bias_i[BIAS_W-1]}}, bias_i};
    assign n_in      = (num_chunk_i == '0) ? CNT_W'(1) : num_chunk_i;
    assign first     = (cnt_q == '0);
    // The group length is only trusted from num_chunk_i on the first beat.
    assign last_idx  = first ? (n_in - CNT_W'(1)) : last_q;
    assign is_last   = (cnt_q == last_idx);
    assign psum_base = first ? '0 : psum_q;

    always_comb begin
        cnt_d      = cnt_q;
        last_d     = last_q;
        psum_d     = psum_q;
        s1_vld_d   = 1'b0;
        s1_sum_d   = s1_sum_q;
        s1_shift_d = s1_shift_q;
        s1_relu_d  = s1_relu_q;
        if (clr_i) begin
            cnt_d  = '0;
            psum_d = '0;
        end else if (vld_i) begin
            if (is_last) begin
                cnt_d      = '0;
                psum_d     = '0;
                s1_vld_d   = 1'b1;
                s1_sum_d   = psum_base + acc_ext + bias_ext;
                s1_shift_d = shift_i;
                s1_relu_d  = relu_en_i;
            end else begin
                cnt_d  = cnt_q + CNT_W'(1);
                psum_d = psum_base + acc_ext;
                if (first) begin
                    last_d = n_in - CNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt_q      <= '0;
            last_q     <= '0;
            psum_q     <= '0;
            s1_sum_q   <= '0;
            s1_shift_q <= '0;
            s1_relu_q  <= 1'b0;
            s1_vld_q   <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            last_q     <= last_d;
            psum_q     <= psum_d;
            s1_sum_q   <= s1_sum_d;
            s1_shift_q <= s1_shift_d;
            s1_relu_q  <= s1_relu_d;
            s1_vld_q   <= s1_vld_d;
        end
    end

    quant_act_sat u_quant_act_sat (
        .clk       (clk),
        .rstn      (rstn),
        .vld_i     (s1_vld_q),
        .sum_i     (s1_sum_q),
        .shift_i   (s1_shift_q),
        .relu_en_i (s1_relu_q),
        .out_o     (out_o),
        .vld_o     (vld_o),
        .sat_o     (sat_w)
    );

`ifdef PSUM_QUANT_SAT_CNT_EN
    logic [15:0] sat_cnt_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sat_cnt_q <= '0;
        end else if (clr_i) begin
            sat_cnt_q <= '0;
        end else if (vld_o && sat_w && (sat_cnt_q != 16'hFFFF)) begin
            sat_cnt_q <= sat_cnt_q + 16'd1;
        end
    end

    assign sat_cnt_o = sat_cnt_q;
`else
    logic unused_sat;
    assign unused_sat = sat_w;
`endif

endmodule

// File: tb/tb_psum_quant.sv
// Directed bench for psum_quant: a group-level model predicts each pixel and
// the cycle it must appear; a negedge monitor checks every output cycle.
module tb_psum_quant;

    logic              clk = 1'b0;
    logic              rstn = 1'b1;
    logic              clr_i = 1'b0;
    logic [9:0]        num_chunk_i = '0;
    logic signed [15:0] bias_i = '0;
    logic [4:0]        shift_i = '0;
    logic              relu_en_i = 1'b0;
    logic              vld_i = 1'b0;
    logic signed [19:0] acc_i = '0;
    logic signed [7:0] out_o;
    logic              vld_o;
`ifdef PSUM_QUANT_SAT_CNT_EN
    logic [15:0]       sat_cnt_o;
`endif

    psum_quant dut (
        .clk         (clk),
        .rstn        (rstn),
        .clr_i       (clr_i),
        .num_chunk_i (num_chunk_i),
        .bias_i      (bias_i),
        .shift_i     (shift_i),
        .relu_en_i   (relu_en_i),
        .vld_i       (vld_i),
        .acc_i       (acc_i),
        .out_o       (out_o),
        .vld_o       (vld_o)
`ifdef PSUM_QUANT_SAT_CNT_EN
       ,.sat_cnt_o   (sat_cnt_o)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int compared = 0;
    int mismatched = 0;

    // scoreboard: expected pixel values and the cycle each must appear
    logic [7:0] exp_q[$];
    int         due_q[$];

    // group model state and current configuration
    int     cfg_n = 1, cfg_bias = 0, cfg_sh = 0;
    bit     cfg_relu = 1'b0;
    int     g_cnt = 0, g_n = 1;
    longint g_sum = 0;

    function automatic longint act_model(longint s, int sh, bit relu);
        longint r;
        r = s;
        if (sh > 0) r = (s + (longint'(1) << (sh - 1))) >>> sh;
        if (relu && r < 0) r = r >>> 3;
        return r;
    endfunction

    function automatic int clamp8(longint a);
        if (a > 127) return 127;
        if (a < -128) return -128;
        return int'(a);
    endfunction

    task automatic chk(string name, int got, int exp);
        compared++;
        if (got != exp) begin
            mismatched++;
            $display("FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    task automatic model_step(bit vld, bit clr, int acc);
        int c;
        if (clr) begin
            g_cnt = 0;
            g_sum = 0;
        end else if (vld) begin
            if (g_cnt == 0) g_n = (cfg_n == 0) ? 1 : cfg_n;
            g_sum += acc;
            g_cnt++;
            if (g_cnt == g_n) begin
                c = clamp8(act_model(g_sum + cfg_bias, cfg_sh, cfg_relu));
                exp_q.push_back(8'(c));
                due_q.push_back(cyc + 3);
                g_cnt = 0;
                g_sum = 0;
            end
        end
    endtask

    task automatic set_cfg(int n, int bias, int sh, bit relu);
        cfg_n = n; cfg_bias = bias; cfg_sh = sh; cfg_relu = relu;
    endtask

    task automatic drive(bit vld, bit clr, int acc);
        vld_i       = vld;
        clr_i       = clr;
        acc_i       = 20'(acc);
        num_chunk_i = 10'(cfg_n);
        bias_i      = 16'(cfg_bias);
        shift_i     = 5'(cfg_sh);
        relu_en_i   = cfg_relu;
        model_step(vld, clr, acc);
        @(posedge clk);
        #1;
        vld_i = 1'b0;
        clr_i = 1'b0;
    endtask

    task automatic beat(int acc);
        drive(1'b1, 1'b0, acc);
    endtask

    task automatic idle(int k);
        for (int i = 0; i < k; i++) drive(1'b0, 1'b0, 0);
    endtask

    // compare process: every cycle outside reset
    always @(negedge clk) begin
        if (rstn) begin
            if (due_q.size() > 0 && due_q[0] == cyc) begin
                compared++;
                if (!vld_o) begin
                    mismatched++;
                    $display("FAIL missing_vld: vld_o=%0b at cycle %0d, expected 1", vld_o, cyc);
                end else if (out_o !== exp_q[0]) begin
                    mismatched++;
                    $display("FAIL out_value: out_o=%0d at cycle %0d, expected %0d",
                             out_o, cyc, $signed(exp_q[0]));
                end
                void'(exp_q.pop_front());
                void'(due_q.pop_front());
            end else if (vld_o) begin
                compared++;
                mismatched++;
                $display("FAIL unexpected_vld: vld_o=1 out_o=%0d at cycle %0d, expected 0", out_o, cyc);
            end
        end
    end

    int tbl_acc[6]  = '{500000, -300000, 77, -7, -1, 255};
    int tbl_bias[6] = '{-32768, 1000, 3, 0, 0, 1};
    int tbl_sh[6]   = '{0, 4, 1, 0, 31, 1};
    bit tbl_relu[6] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};

    initial begin
        // model pins from hand arithmetic
        chk("model_sum3000_sh5", clamp8(act_model(3000, 5, 1'b0)), 94);
        chk("model_neg_leaky", clamp8(act_model(-800, 2, 1'b1)), -25);
        chk("model_neg_sat", clamp8(act_model(-800, 2, 1'b0)), -128);
        chk("model_leaky_floor", clamp8(act_model(-7, 0, 1'b1)), -1);

        #2 rstn = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_out", int'(out_o), 0);
        chk("reset_vld", int'(vld_o), 0);
        rstn = 1'b1;
        idle(2);

        // 1: single chunk passthrough
        set_cfg(1, 0, 0, 1'b1);
        beat(100);
        idle(5);

        // 2: four chunks back-to-back with bias and shift
        set_cfg(4, 200, 5, 1'b0);
        beat(1000); beat(2000); beat(-500); beat(300);
        idle(5);

        // 3: negative sum, leaky then linear saturating
        set_cfg(1, 0, 2, 1'b1);
        beat(-800);
        set_cfg(1, 0, 2, 1'b0);
        beat(-800);
        idle(5);
`ifdef PSUM_QUANT_SAT_CNT_EN
        chk("sat_cnt_after_clip", int'(sat_cnt_o), 1);
`endif

        // 4: idle gap inside a group
        set_cfg(2, 0, 0, 1'b0);
        beat(60);
        idle(5);
        beat(40);
        idle(5);

        // 5: aborted group, then clr coincident with a beat
        set_cfg(3, 0, 0, 1'b0);
        beat(7); beat(7);
        drive(1'b0, 1'b1, 0);
        beat(10); beat(10); beat(10);
        idle(5);
        set_cfg(1, 0, 0, 1'b0);
        drive(1'b1, 1'b1, 9);
        beat(3);
        idle(5);

        // full throughput with changing config; num_chunk 0 behaves as 1
        for (int i = 0; i < 6; i++) begin
            set_cfg((i == 2) ? 0 : 1, tbl_bias[i], tbl_sh[i], tbl_relu[i]);
            beat(tbl_acc[i]);
        end
        idle(5);

        // 6: reset while a pixel sits in S2
        set_cfg(1, 0, 0, 1'b0);
        beat(77);
        idle(1);
        rstn = 1'b0;
        exp_q.delete();
        due_q.delete();
        g_cnt = 0;
        g_sum = 0;
        #1;
        chk("rst_mid_out", int'(out_o), 0);
        chk("rst_mid_vld", int'(vld_o), 0);
        repeat (2) @(posedge clk);
        #1 rstn = 1'b1;
        idle(1);
        beat(5);
        idle(6);

        chk("scoreboard_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/psum_quant.md
Name: psum_quant

Overview:
- Sits directly downstream of the 16-lane MAC.
- Consumes its signed 20-bit adder-tree result (acc/vld) and accumulates partial sums over the input-channel chunks of one output pixel.
- Then adds bias, applies rounding right shift, optional leaky ReLU, and saturation, producing one int8 activation per output pixel for the output buffer.

Parameters:
- IN_W, 20, width of signed partial sum from MAC
- ACC_W, 32, internal accumulator width; must be ≥ IN_W+CNT_W
- BIAS_W, 16, signed bias width
- OUT_W, 8, signed output width
- CNT_W, 10, chunk counter width (max 1023 chunks per pixel)

Ports:
- clk  in  1  clock
- rstn  in  1  async active-low reset
- clr_i  in  1  sync clear of group state (layer start / abort)
- num_chunk_i  in  CNT_W  partial sums per output pixel; 0 treated as 1
- bias_i  in  BIAS_W  signed bias for current pixel
- shift_i  in  5  requantization right shift, 0..31
- relu_en_i  in  1  1 = leaky ReLU, 0 = linear
- vld_i  in  1  partial sum valid
- acc_i  in  IN_W  signed partial sum
- out_o  out  OUT_W  signed quantized activation
- vld_o  out  1  out_o valid, single-cycle pulse per pixel

Behaviour:
- Reset: rstn is asynchronous, active-low; clock is clk. Asynchronous reset clears cnt, psum, all pipeline registers, out_o=0, vld_o=0. Deasserting rstn mid-operation discards in-flight data.
- All arithmetic is two's complement. acc_i and bias_i are sign-extended to ACC_W. Accumulator overflow wraps and is not detected.
- Group counter cnt:
  - 0..N-1, where N = max(num_chunk_i,1).
  - N is latched on the first beat of a group (cnt==0 && vld_i).
  - Advances only on vld_i. Idle cycles between beats are allowed and are unlimited.
- Accumulation:
  - First beat: psum <= sext(acc_i).
  - Later beats: psum <= psum + sext(acc_i).
  - Last beat (cnt==N-1): S1 <= psum_in + sext(acc_i) + sext(bias_i). psum_in is 0 when N==1.
  - bias_i, shift_i, relu_en_i are sampled on the last beat and travel with the data. Back-to-back groups with different config are therefore legal.
- Pipeline:
  - Stage S1: final sum.
  - Stage S2: round-shift. If shift>0, R = (S + 2^(shift-1)) >>> shift; otherwise R = S.
  - Stage S3:
    - Activation: if relu_en and R<0, A = R >>> 3 (floor); otherwise A = R.
    - Saturate A to [-128,127] and register into out_o.
  - vld_o asserts exactly 3 cycles after the vld_i of the last beat.
  - Full throughput: with N=1, one output per cycle. No backpressure.
- clr_i: synchronous. Next cycle cnt=0 and psum=0. A beat coincident with clr_i is dropped (clr wins). Pixels already in S1..S3 still emit.
- out_o holds its last value when vld_o=0.

Optional Feature:
- Macro: PSUM_QUANT_SAT_CNT_EN.
- Defined:
  - Adds output port sat_cnt_o [15:0].
  - Increments on each vld_o where saturation clipped the value.
  - Sticks at 16'hFFFF (no wrap).
  - Cleared by rstn and clr_i.
- Undefined: port and logic absent. Functional outputs are identical either way.

Decomposition:
- Shared package holds:
  - width constants IN_W/ACC_W/BIAS_W/OUT_W
  - LEAKY_SHIFT=3
  - OUT_MAX=127, OUT_MIN=-128
  - typedefs for the signed psum and output
- One natural sub-module: quant_act_sat (stages S2–S3: round-shift, leaky ReLU, saturate). It is reusable by the pooling and shortcut paths.
- The accumulator and counter stay in the top module.

Test Plan:
1. N=1, acc_i=100, bias=0, shift=0, relu=1 → out_o=100, vld_o exactly 3 cycles after vld_i.
2. N=4, acc_i=1000,2000,-500,300 back-to-back, bias=200, shift=5 → sum 3000, out_o=94; one vld_o only.
3. N=1, acc_i=-800, bias=0, shift=2:
   - relu=1 → R=-200, out_o=-25.
   - relu=0 → out_o=-128, and sat_cnt_o increments if macro defined.
4. N=2, beats 60 and 40 separated by 5 idle cycles, shift=0, bias=0 → out_o=100, vld_o 3 cycles after second beat; no output after first.
5. N=3, two beats of 7, then clr_i, then three beats of 10 (shift 0, bias 0) → single out_o=30; aborted group never emits. Also check clr_i coincident with vld_i drops that beat.
6. rstn asserted while a pixel is in S2 → vld_o and out_o go 0 immediately; after release, N=1 acc_i=5 → out_o=5.
